data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-through, no-write-allocate data cache placed between the memory-stage ALU result and `main_memory`. It is the responder to the core's load/store requests and the initiator toward backing memory. On a read miss or any store, it raises `stall_o` to the hazard unit until the transaction completes. Word accesses only.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width; also the address width.
- `INDEX_BITS`, 3: set-index width, giving 2^INDEX_BITS lines of one word each.

Ports:
- `clk_i`, in, 1: clock; all state updates on the rising edge.
- `rst_i`, in, 1: synchronous, active-high reset.
- `req_i`, in, 1: the memory stage holds a load or store.
- `write_enable_i`, in, 1: 1 = store, 0 = load. Qualified by `req_i`.
- `address_i`, in, DATA_WIDTH: byte address; bits [1:0] ignored.
- `write_value_i`, in, DATA_WIDTH: store data.
- `read_value_o`, out, DATA_WIDTH: load data. Valid when `req_i & ~write_enable_i & ~stall_o`.
- `stall_o`, out, 1: combinational stall request to the hazard unit.
- `mem_req_o`, out, 1: backing-memory request.
- `mem_write_o`, out, 1: 1 = write, 0 = read.
- `mem_addr_o`, out, DATA_WIDTH: word-aligned address, with [1:0] = 0.
- `mem_wdata_o`, out, DATA_WIDTH: write data.
- `mem_rdata_i`, in, DATA_WIDTH: read data, valid with `mem_ack_i`.
- `mem_ack_i`, in, 1: one-cycle completion pulse.

## Operation
Address decode:
- index = `address_i[INDEX_BITS+1:2]`
- tag = `address_i[DATA_WIDTH-1:INDEX_BITS+2]`
- hit = the line is valid and its stored tag equals the tag.

The FSM has four states, IDLE, MISS, WRITE and WDONE:
- **IDLE**
  - Load hit: `read_value_o` = line data and `stall_o`=0; stay in IDLE.
  - Load miss: `stall_o`=1; latch the word address; go to MISS.
  - Store: `stall_o`=1. On a hit, update the line data this edge. Latch the address and data; go to WRITE.
  - `req_i`=0: no action.
- **MISS**
  - `mem_req_o`=1 and `mem_write_o`=0; `stall_o`=1.
  - On `mem_ack_i`, fill the line: valid=1, tag, data = `mem_rdata_i`. Go to IDLE.
  - The still-held load then hits in IDLE (replay).
- **WRITE**
  - `mem_req_o`=1 and `mem_write_o`=1; `stall_o`=1.
  - On `mem_ack_i`, go to WDONE.
- **WDONE**
  - `stall_o`=0 and `req_i` is ignored for this one cycle, so the held store is retired and not reissued.
  - Go to IDLE.

Rules:
- `read_value_o` = 0 whenever the IDLE-state lookup is not a load hit.
- A store miss leaves the cache contents unchanged (no allocate).
- `mem_addr_o`, `mem_wdata_o` and `mem_write_o` are driven from registers and stay stable while `mem_req_o`=1.
- `mem_ack_i` is ignored in IDLE and WDONE.
- Reset:
  - clears all valid bits and forces IDLE;
  - sets `mem_req_o`=0 and the address/data registers to 0;
  - abandons any in-flight transaction.
  - An ack arriving after reset is ignored.

## Timing
- Load hit: zero added cycles; data is combinational from the array read.
- Load miss accepted in cycle T:
  - `mem_req_o` is high from T+1.
  - Ack arrives in cycle A ≥ T+1; the line is written at the end of A.
  - In A+1 the lookup hits, `stall_o`=0 and the data is presented.
  - Minimum penalty: 2 stall cycles.
- Store accepted in T:
  - Stall covers T through A.
  - WDONE is in A+1 with `stall_o`=0.
  - Minimum penalty: 2 stall cycles.
- Back-to-back accesses: a new request is accepted in IDLE the cycle after WDONE or after a replayed load hit.
- Reset values after the reset edge: state = IDLE, `mem_req_o`=0, `mem_write_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0. `stall_o` and `read_value_o` follow the IDLE equations.

## Structure
- Package `data_cache_pkg` holds:
  - the `cache_state_t` enum (IDLE, MISS, WRITE, WDONE);
  - the localparams `TAG_BITS` = DATA_WIDTH−INDEX_BITS−2 and `LINES` = 2^INDEX_BITS.
- Sub-module `data_cache_array` holds the valid, tag and data arrays. It has:
  - an asynchronous read port;
  - one synchronous write port for a fill or a store-hit update;
  - a synchronous clear of all valid bits.
- The top level contains the FSM, the request registers and the stall logic.

## Test plan
- After reset, load from 0x40: `stall_o`=1 and a memory read is issued to 0x40. Ack with 0xDEADBEEF after 3 cycles; the next cycle gives `read_value_o`=0xDEADBEEF with `stall_o`=0. A repeat load of 0x40 hits with zero stall.
- Store 0x12345678 to 0x40 (a hit): memory write to 0x40 with 0x12345678. WDONE gives `stall_o`=0 for one cycle with no second write. A following load of 0x40 hits and returns 0x12345678.
- Store to 0x80 (a miss): memory write is issued. A following load of 0x80 misses and a memory read is issued (no allocate).
- Conflict: load 0x40, then load 0x60 (same index 0, different tag), then load 0x40. The third load misses again.
- Reset asserted during MISS with the ack arriving the same or next cycle: `mem_req_o`=0 the cycle after reset, the ack is ignored, and a load of 0x40 then misses.
- Load to 0x43: `mem_addr_o`=0x40, and the access hits the same line as 0x40.

Source files
------------

// File: rtl/data_cache_pkg.sv
// Shared types and default geometry for the direct-mapped write-through data cache.
package data_cache_pkg;

   localparam int unsigned DC_DATA_WIDTH = 32;
   localparam int unsigned DC_INDEX_BITS = 3;
   localparam int unsigned TAG_BITS      = DC_DATA_WIDTH - DC_INDEX_BITS - 2;
   localparam int unsigned LINES         = 1 << DC_INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE,
      MISS,
      WRITE,
      WDONE
   } cache_state_t;

endpackage

// File: rtl/data_cache_if.sv
// Core-side load/store request plus backing-memory bus, as seen by the data cache.
interface data_cache_if #(
   parameter int unsigned DATA_WIDTH = 32
) ();

   logic                  req_i;
   logic                  write_enable_i;
   logic [DATA_WIDTH-1:0] address_i;
   logic [DATA_WIDTH-1:0] write_value_i;
   logic [DATA_WIDTH-1:0] read_value_o;
   logic                  stall_o;

   logic                  mem_req_o;
   logic                  mem_write_o;
   logic [DATA_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_wdata_o;
   logic [DATA_WIDTH-1:0] mem_rdata_i;
   logic                  mem_ack_i;

   // Cache view.
   modport slave (
      input  req_i, write_enable_i, address_i, write_value_i, mem_rdata_i, mem_ack_i,
      output read_value_o, stall_o, mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o
   );

   // Core and memory view.
   modport master (
      output req_i, write_enable_i, address_i, write_value_i, mem_rdata_i, mem_ack_i,
      input  read_value_o, stall_o, mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o
   );

endinterface

// File: rtl/data_cache_array.sv
// Valid/tag/data storage: asynchronous read, one synchronous write, synchronous valid clear.
module data_cache_array #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned INDEX_BITS = 3,
   parameter int unsigned TAG_WIDTH  = 27
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [INDEX_BITS-1:0] rdIndex_i,
   output logic                  rdValid_o,
   output logic [TAG_WIDTH-1:0]  rdTag_o,
   output logic [DATA_WIDTH-1:0] rdData_o,
   input  logic                  wrEn_i,
   input  logic [INDEX_BITS-1:0] wrIndex_i,
   input  logic [TAG_WIDTH-1:0]  wrTag_i,
   input  logic [DATA_WIDTH-1:0] wrData_i
);

   localparam int unsigned NumLines = 1 << INDEX_BITS;

   logic [NumLines-1:0]   valid_q;
   logic [TAG_WIDTH-1:0]  tag_q  [NumLines];
   logic [DATA_WIDTH-1:0] data_q [NumLines];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
      end else if (wrEn_i) begin
         valid_q[wrIndex_i] <= 1'b1;
      end
   end

   // Tag and data need no reset; a cleared valid bit masks them.
   always_ff @(posedge clk_i) begin
      if (wrEn_i) begin
         tag_q[wrIndex_i]  <= wrTag_i;
         data_q[wrIndex_i] <= wrData_i;
      end
   end

   assign rdValid_o = valid_q[rdIndex_i];
   assign rdTag_o   = tag_q[rdIndex_i];
   assign rdData_o  = data_q[rdIndex_i];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the memory stage and
// backing memory. Stalls the core on read misses and on every store.
module data_cache
   import data_cache_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DC_DATA_WIDTH,
   parameter int unsigned INDEX_BITS = DC_INDEX_BITS
) (
   input logic         clk_i,
   input logic         rst_i,
   data_cache_if.slave bus
);

   localparam int unsigned TagWidth = DATA_WIDTH - INDEX_BITS - 2;

   cache_state_t          state_q;
   logic                  memReq_q;
   logic                  memWrite_q;
   logic [DATA_WIDTH-1:0] memAddr_q;
   logic [DATA_WIDTH-1:0] memWdata_q;

   logic [INDEX_BITS-1:0] reqIndex;
   logic [TagWidth-1:0]   reqTag;
   logic                  lineValid;
   logic [TagWidth-1:0]   lineTag;
   logic [DATA_WIDTH-1:0] lineData;
   logic                  hit;
   logic                  loadHit;
   logic                  storeHit;
   logic                  fill;
   logic                  needMem;

   logic                  arrWrEn;
   logic [INDEX_BITS-1:0] arrWrIndex;
   logic [TagWidth-1:0]   arrWrTag;
   logic [DATA_WIDTH-1:0] arrWrData;

   logic                  unusedByteOffset;

   assign unusedByteOffset = ^bus.address_i[1:0];

   assign reqIndex = bus.address_i[INDEX_BITS+1:2];
   assign reqTag   = bus.address_i[DATA_WIDTH-1:INDEX_BITS+2];
   assign hit      = lineValid && (lineTag == reqTag);

   assign loadHit  = (state_q == IDLE) && bus.req_i && !bus.write_enable_i && hit;
   assign storeHit = (state_q == IDLE) && bus.req_i && bus.write_enable_i && hit;
   assign fill     = (state_q == MISS) && bus.mem_ack_i;
   // Any store or a load miss must go to memory.
   assign needMem  = bus.req_i && (bus.write_enable_i || !hit);

   data_cache_array #(
      .DATA_WIDTH(DATA_WIDTH),
      .INDEX_BITS(INDEX_BITS),
      .TAG_WIDTH (TagWidth)
   ) u_array (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .rdIndex_i(reqIndex),
      .rdValid_o(lineValid),
      .rdTag_o  (lineTag),
      .rdData_o (lineData),
      .wrEn_i   (arrWrEn),
      .wrIndex_i(arrWrIndex),
      .wrTag_i  (arrWrTag),
      .wrData_i (arrWrData)
   );

   // A fill takes its line from the latched miss address; a store hit from the live request.
   always_comb begin
      arrWrEn    = !rst_i && (fill || storeHit);
      arrWrIndex = reqIndex;
      arrWrTag   = reqTag;
      arrWrData  = bus.write_value_i;
      if (fill) begin
         arrWrIndex = memAddr_q[INDEX_BITS+1:2];
         arrWrTag   = memAddr_q[DATA_WIDTH-1:INDEX_BITS+2];
         arrWrData  = bus.mem_rdata_i;
      end
   end

   always_comb begin
      bus.stall_o = 1'b0;
      unique case (state_q)
         IDLE:        bus.stall_o = needMem;
         MISS, WRITE: bus.stall_o = 1'b1;
         WDONE:       bus.stall_o = 1'b0;
         default:     bus.stall_o = 1'b0;
      endcase
   end

   assign bus.read_value_o = loadHit ? lineData : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         memReq_q   <= 1'b0;
         memWrite_q <= 1'b0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (needMem) begin
                  memReq_q   <= 1'b1;
                  memWrite_q <= bus.write_enable_i;
                  memAddr_q  <= {bus.address_i[DATA_WIDTH-1:2], 2'b00};
                  if (bus.write_enable_i) begin
                     memWdata_q <= bus.write_value_i;
                  end
                  state_q <= bus.write_enable_i ? WRITE : MISS;
               end
            end
            MISS: begin
               if (bus.mem_ack_i) begin
                  memReq_q <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            WRITE: begin
               if (bus.mem_ack_i) begin
                  memReq_q <= 1'b0;
                  state_q  <= WDONE;
               end
            end
            // Held store retires here; req_i is deliberately not sampled.
            WDONE:   state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.mem_req_o   = memReq_q;
   assign bus.mem_write_o = memWrite_q;
   assign bus.mem_addr_o  = memAddr_q;
   assign bus.mem_wdata_o = memWdata_q;

   a_mem_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (bus.mem_req_o && !bus.mem_ack_i) |=>
      $stable({bus.mem_write_o, bus.mem_addr_o, bus.mem_wdata_o}));

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus random traffic against a
// line-level cache model and a word-addressed memory model.
module tb_data_cache;
   import data_cache_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nCompared   = 0;
   int   nMismatched = 0;

   bit          mValid [LINES];
   logic [31:0] mTag   [LINES];
   logic [31:0] mData  [LINES];
   logic [31:0] memModel [logic [31:0]];

   data_cache_if #(.DATA_WIDTH(DC_DATA_WIDTH)) bus ();

   data_cache #(
      .DATA_WIDTH(DC_DATA_WIDTH),
      .INDEX_BITS(DC_INDEX_BITS)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model;
      foreach (mValid[i]) mValid[i] = 1'b0;
   endtask

   // One load or store from acceptance to retirement; entered and left at posedge+1.
   task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input int delay, input bit gap, input string name);
      logic [31:0] wa;
      logic [31:0] tag;
      int          idx;
      bit          hit;
      wa  = {addr[31:2], 2'b00};
      idx = int'((addr >> 2) % LINES);
      tag = addr >> (DC_INDEX_BITS + 2);
      hit = mValid[idx] && (mTag[idx] == tag);
      if (!memModel.exists(wa)) memModel[wa] = $urandom;
      bus.req_i = 1'b1;
      bus.write_enable_i = we;
      bus.address_i = addr;
      bus.write_value_i = wdata;
      @(negedge clk);
      if (!we && hit) begin
         nCompared++;
         if (bus.stall_o !== 1'b0) begin
            nMismatched++;
            $display("FAIL %s hit-stall: got %b want 0", name, bus.stall_o);
         end
         nCompared++;
         if (bus.read_value_o !== mData[idx]) begin
            nMismatched++;
            $display("FAIL %s hit-data: got %h want %h", name, bus.read_value_o, mData[idx]);
         end
      end else begin
         nCompared++;
         if (bus.stall_o !== 1'b1 || bus.read_value_o !== 32'h0) begin
            nMismatched++;
            $display("FAIL %s accept: stall=%b rv=%h want stall=1 rv=0", name, bus.stall_o,
                     bus.read_value_o);
         end
         for (int c = 1; c <= delay; c++) begin
            tick();
            if (c == delay) begin
               bus.mem_ack_i = 1'b1;
               bus.mem_rdata_i = we ? $urandom : memModel[wa];
            end
            @(negedge clk);
            nCompared++;
            if (bus.mem_req_o !== 1'b1 || bus.mem_write_o !== we || bus.mem_addr_o !== wa ||
                bus.stall_o !== 1'b1) begin
               nMismatched++;
               $display("FAIL %s membus c%0d: req=%b wr=%b addr=%h stall=%b want 1 %b %h 1",
                        name, c, bus.mem_req_o, bus.mem_write_o, bus.mem_addr_o, bus.stall_o,
                        we, wa);
            end
            if (we) begin
               nCompared++;
               if (bus.mem_wdata_o !== wdata) begin
                  nMismatched++;
                  $display("FAIL %s wdata: got %h want %h", name, bus.mem_wdata_o, wdata);
               end
            end
         end
         tick();
         bus.mem_ack_i = 1'b0;
         bus.mem_rdata_i = $urandom;
         @(negedge clk);
         nCompared++;
         if (bus.stall_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin
            nMismatched++;
            $display("FAIL %s complete: stall=%b mem_req=%b want 0 0", name, bus.stall_o,
                     bus.mem_req_o);
         end
         if (!we) begin
            nCompared++;
            if (bus.read_value_o !== memModel[wa]) begin
               nMismatched++;
               $display("FAIL %s replay-data: got %h want %h", name, bus.read_value_o,
                        memModel[wa]);
            end
            mValid[idx] = 1'b1;
            mTag[idx]   = tag;
            mData[idx]  = memModel[wa];
         end else begin
            memModel[wa] = wdata;
            if (hit) mData[idx] = wdata;
         end
      end
      tick();
      if (gap) begin
         bus.req_i = 1'b0;
         bus.write_enable_i = 1'($urandom);
         bus.address_i = $urandom;
         bus.write_value_i = $urandom;
         @(negedge clk);
         nCompared++;
         if (bus.stall_o !== 1'b0 || bus.mem_req_o !== 1'b0 || bus.read_value_o !== 32'h0) begin
            nMismatched++;
            $display("FAIL %s idle: stall=%b mem_req=%b rv=%h want 0 0 0", name, bus.stall_o,
                     bus.mem_req_o, bus.read_value_o);
         end
         tick();
      end
   endtask

   task automatic test_reset;
      bus.req_i = 1'b0;
      bus.mem_ack_i = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      nCompared++;
      if (bus.mem_req_o !== 1'b0 || bus.mem_write_o !== 1'b0 || bus.mem_addr_o !== 32'h0 ||
          bus.mem_wdata_o !== 32'h0 || bus.stall_o !== 1'b0 || bus.read_value_o !== 32'h0) begin
         nMismatched++;
         $display("FAIL reset: req=%b wr=%b addr=%h wdata=%h stall=%b rv=%h want all 0",
                  bus.mem_req_o, bus.mem_write_o, bus.mem_addr_o, bus.mem_wdata_o,
                  bus.stall_o, bus.read_value_o);
      end
      clear_model();
      tick();
   endtask

   task automatic test_load_miss_hit;
      memModel[32'h40] = 32'hDEAD_BEEF;
      run_access(1'b0, 32'h40, 32'h0, 3, 1'b1, "load40-miss");
      run_access(1'b0, 32'h40, 32'h0, 1, 1'b1, "load40-hit");
   endtask

   task automatic test_store_hit;
      run_access(1'b1, 32'h40, 32'h1234_5678, 2, 1'b1, "store40-hit");
      run_access(1'b0, 32'h40, 32'h0, 1, 1'b1, "load40-after-store");
   endtask

   task automatic test_store_miss;
      run_access(1'b1, 32'h80, 32'hCAFE_F00D, 1, 1'b1, "store80-miss");
      run_access(1'b0, 32'h80, 32'h0, 2, 1'b1, "load80-noalloc");
   endtask

   task automatic test_conflict;
      run_access(1'b0, 32'h40, 32'h0, 1, 1'b1, "conflict-a");
      run_access(1'b0, 32'h60, 32'h0, 2, 1'b1, "conflict-b");
      run_access(1'b0, 32'h40, 32'h0, 1, 1'b1, "conflict-c");
   endtask

   task automatic test_unaligned;
      run_access(1'b0, 32'h60, 32'h0, 1, 1'b1, "evict40");
      run_access(1'b0, 32'h43, 32'h0, 2, 1'b1, "load43-miss");
      run_access(1'b0, 32'h40, 32'h0, 1, 1'b1, "load40-samel");
      run_access(1'b0, 32'h41, 32'h0, 1, 1'b1, "load41-samel");
   endtask

   task automatic test_back_to_back;
      run_access(1'b1, 32'h104, 32'hA5A5_0001, 1, 1'b0, "b2b-store");
      run_access(1'b0, 32'h104, 32'h0, 1, 1'b0, "b2b-load");
      run_access(1'b0, 32'h104, 32'h0, 1, 1'b0, "b2b-hit");
      run_access(1'b1, 32'h104, 32'hA5A5_0002, 2, 1'b0, "b2b-store2");
      run_access(1'b0, 32'h104, 32'h0, 1, 1'b1, "b2b-final");
   endtask

   task automatic test_reset_in_miss(input bit ackSameCycle);
      test_reset();
      bus.req_i = 1'b1;
      bus.write_enable_i = 1'b0;
      bus.address_i = 32'h40;
      @(negedge clk);
      nCompared++;
      if (bus.stall_o !== 1'b1) begin
         nMismatched++;
         $display("FAIL rstmiss accept: stall=%b want 1", bus.stall_o);
      end
      tick();
      @(negedge clk);
      nCompared++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h40) begin
         nMismatched++;
         $display("FAIL rstmiss issue: req=%b addr=%h want 1 00000040", bus.mem_req_o,
                  bus.mem_addr_o);
      end
      tick();
      rst = 1'b1;
      bus.mem_ack_i = ackSameCycle;
      bus.mem_rdata_i = 32'hBAD0_0001;
      tick();
      rst = 1'b0;
      bus.req_i = 1'b0;
      bus.mem_ack_i = !ackSameCycle;
      @(negedge clk);
      nCompared++;
      if (bus.mem_req_o !== 1'b0 || bus.stall_o !== 1'b0) begin
         nMismatched++;
         $display("FAIL rstmiss after-reset: req=%b stall=%b want 0 0", bus.mem_req_o,
                  bus.stall_o);
      end
      tick();
      bus.mem_ack_i = 1'b0;
      @(negedge clk);
      nCompared++;
      if (bus.mem_req_o !== 1'b0) begin
         nMismatched++;
         $display("FAIL rstmiss late-ack: req=%b want 0", bus.mem_req_o);
      end
      tick();
      clear_model();
      run_access(1'b0, 32'h40, 32'h0, 2, 1'b1, "rstmiss-reload");
   endtask

   task automatic test_random;
      logic [31:0] tags [4];
      logic [31:0] addr;
      tags[0] = 32'h0;
      tags[1] = 32'h1;
      tags[2] = 32'h123;
      tags[3] = 32'h7FF_FFFF;
      for (int n = 0; n < 150; n++) begin
         addr = (tags[$urandom_range(0, 3)] << (DC_INDEX_BITS + 2)) |
                (32'($urandom_range(0, LINES - 1)) << 2) | 32'($urandom_range(0, 3));
         run_access(1'($urandom), addr, $urandom, int'($urandom_range(1, 4)), 1'($urandom),
                    "random");
      end
   endtask

   initial begin
      bus.req_i = 1'b0;
      bus.write_enable_i = 1'b0;
      bus.address_i = 32'h0;
      bus.write_value_i = 32'h0;
      bus.mem_rdata_i = 32'h0;
      bus.mem_ack_i = 1'b0;
      test_reset();
      test_load_miss_hit();
      test_store_hit();
      test_store_miss();
      test_conflict();
      test_unaligned();
      test_back_to_back();
      test_reset_in_miss(1'b1);
      test_reset_in_miss(1'b0);
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
